// File: rtl/fifo_merge_arbiter_pkg.sv
// Shared types for the FIFO merge arbiter:
// FSM state encoding and priority-mode constants.
package fifo_merge_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic PRIO_RR    = 1'b0;
  localparam logic PRIO_FIXED = 1'b1;

endpackage

// File: rtl/fifo_merge_arbiter_if.sv
// Channel-side and downstream-side bundle of the merge arbiter.
// master: arbiter view (drives grants/output); slave: environment view.
interface fifo_merge_arbiter_if #(
  parameter int WIDTH      = 5,
  parameter int DATA_WIDTH = 32
);
  logic [WIDTH-1:0]            WRITE_REQ;
  logic [WIDTH-1:0]            HOLD_REQ;
  logic [WIDTH*DATA_WIDTH-1:0] DATA_IN;
  logic [WIDTH-1:0]            CHANNEL_EN;
  logic                        PRIO_MODE;
  logic [WIDTH-1:0]            READ_GRANT;
  logic                        READY_OUT;
  logic                        WRITE_OUT;
  logic [DATA_WIDTH-1:0]       DATA_OUT;
  logic [3:0]                  CUR_CH;
  logic                        BUSY;

  modport master (
    input  WRITE_REQ, HOLD_REQ, DATA_IN,
    input  CHANNEL_EN, PRIO_MODE, READY_OUT,
    output READ_GRANT, WRITE_OUT, DATA_OUT,
    output CUR_CH, BUSY
  );

  modport slave (
    output WRITE_REQ, HOLD_REQ, DATA_IN,
    output CHANNEL_EN, PRIO_MODE, READY_OUT,
    input  READ_GRANT, WRITE_OUT, DATA_OUT,
    input  CUR_CH, BUSY
  );
endinterface

// File: rtl/fifo_merge_arbiter_rr_pick.sv
// Combinational channel picker: eligible mask, start index, mode
// -> one-hot pick, binary index and any-eligible flag.
module rr_pick
  import fifo_merge_arbiter_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] elig,
  input  logic [3:0]       start,
  input  logic             mode,
  output logic [WIDTH-1:0] onehot,
  output logic [3:0]       idx,
  output logic             any
);

  logic [2*WIDTH-1:0] dbl;
  logic [WIDTH-1:0]   rot;
  logic [4:0]         base;
  logic [4:0]         pos;

  // Rotate the doubled mask so bit 0 is the first
  // position searched, then take the first set bit.
  always_comb begin
    base   = (mode == PRIO_FIXED) ? 5'd0 : {1'b0, start};
    dbl    = {elig, elig} >> base;
    rot    = dbl[WIDTH-1:0];
    onehot = '0;
    any    = 1'b0;
    pos    = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (!any && rot[k]) begin
        any = 1'b1;
        pos = base + 5'(k);
        if (pos >= 5'(WIDTH)) pos = pos - 5'(WIDTH);
      end
    end
    idx = pos[3:0];
    for (int j = 0; j < WIDTH; j++) begin
      onehot[j] = any && (pos == 5'(j));
    end
  end

endmodule

// File: rtl/fifo_merge_arbiter.sv
// Merges WIDTH FWFT sources into one registered output stream.
// Ports: CLK, RST (sync, active-high), bus (master modport).
module fifo_merge_arbiter
  import fifo_merge_arbiter_pkg::*;
#(
  parameter int WIDTH      = 5,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input logic                 CLK,
  input logic                 RST,
  fifo_merge_arbiter_if.master bus
);

  localparam int CW =
    (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [CW-1:0] BMAX = CW'(MAX_BURST);
  localparam logic [3:0] LAST_IDX = 4'(WIDTH - 1);

  state_t                  state, state_nx;
  logic [3:0]              cur_ch, last_ch, start;
  logic [WIDTH-1:0]        cur_oh;
  logic [CW-1:0]           cnt;
  logic                    wout;
  logic [DATA_WIDTH-1:0]   dout, din;
  logic [WIDTH-1:0]        elig, pick_oh;
  logic [3:0]              pick_idx;
  logic                    pick_any;
  logic                    cur_req, cur_en, cur_hold;
  logic                    free, limit_hit, release_g;
  logic                    pop;

  assign elig  = bus.WRITE_REQ & bus.CHANNEL_EN;
  assign start = (last_ch == LAST_IDX) ? 4'd0
                                       : last_ch + 4'd1;

  rr_pick #(.WIDTH(WIDTH)) u_pick (
    .elig   (elig),
    .start  (start),
    .mode   (bus.PRIO_MODE),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign cur_req  = |(bus.WRITE_REQ  & cur_oh);
  assign cur_en   = |(bus.CHANNEL_EN & cur_oh);
  assign cur_hold = |(bus.HOLD_REQ   & cur_oh);
  assign free     = !wout || bus.READY_OUT;
  assign limit_hit = (MAX_BURST != 0) && (cnt == BMAX);
  assign release_g =
    !cur_hold && (!cur_req || limit_hit || !cur_en);

  always_comb begin
    din = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (cur_oh[i])
        din = din | bus.DATA_IN[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Release cycle never pops; RST also blocks the pop so
  // the source keeps its word.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_any) state_nx = GRANT;
      end
      GRANT: begin
        if (release_g) state_nx = IDLE;
        else pop = cur_req && cur_en && free && !RST;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cur_ch  <= '0;
      cur_oh  <= WIDTH'(1);
      last_ch <= LAST_IDX;
      cnt     <= '0;
      wout    <= 1'b0;
      dout    <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && pick_any) begin
        cur_ch  <= pick_idx;
        cur_oh  <= pick_oh;
        last_ch <= pick_idx;
        cnt     <= '0;
      end
      if (pop) begin
        dout <= din;
        wout <= 1'b1;
        if (MAX_BURST != 0 && cnt != BMAX)
          cnt <= cnt + CW'(1);
      end else if (bus.READY_OUT) begin
        wout <= 1'b0;
      end
    end
  end

  assign bus.READ_GRANT = pop ? cur_oh : '0;
  assign bus.WRITE_OUT  = wout;
  assign bus.DATA_OUT   = dout;
  assign bus.CUR_CH     = cur_ch;
  assign bus.BUSY       = (state == GRANT);

endmodule

// File: tb/tb_fifo_merge_arbiter.sv
// Scoreboard bench: queue-based sources, abstract arbitration
// model builds expected stream, monitor checks output order.
module tb_fifo_merge_arbiter;
  import fifo_merge_arbiter_pkg::*;

  localparam int W  = 5;
  localparam int DW = 32;
  localparam int MB = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  fifo_merge_arbiter_if #(.WIDTH(W), .DATA_WIDTH(DW)) bus();

  fifo_merge_arbiter #(
    .WIDTH(W), .DATA_WIDTH(DW), .MAX_BURST(MB)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] src[W][$];
  logic [DW-1:0] exp_q[$];
  int            acc_cyc[$];
  int            mcyc = 0;
  int            seq  = 0;

  logic          rst_c = 1'b1;
  logic [W-1:0]  hold  = '0;
  logic [W-1:0]  en    = '1;
  logic          mode  = 1'b0;
  int            rmode = 0;
  logic          rdy   = 1'b1;
  logic          pend  = 1'b0;
  logic [DW-1:0] pend_w;

  task automatic chk(input string nm,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic load(input int ch, input int n);
    for (int j = 0; j < n; j++) begin
      seq++;
      src[ch].push_back({4'(ch), 12'(seq), 16'($urandom)});
    end
  endtask

  task automatic drive();
    RST            = rst_c;
    bus.HOLD_REQ   = hold;
    bus.CHANNEL_EN = en;
    bus.PRIO_MODE  = mode;
    case (rmode)
      0:       rdy = 1'b1;
      1:       rdy = ~rdy;
      default: rdy = ($urandom_range(0, 99) < 70);
    endcase
    bus.READY_OUT = rdy;
    for (int i = 0; i < W; i++) begin
      bus.WRITE_REQ[i] = (src[i].size() != 0);
      bus.DATA_IN[i*DW +: DW] =
        (src[i].size() != 0) ? src[i][0] : '0;
    end
  endtask

  task automatic sample();
    if (pend) begin
      chk("latency_valid", DW'(bus.WRITE_OUT), 1);
      chk("latency_data", bus.DATA_OUT, pend_w);
      pend = 1'b0;
    end
    if (bus.READ_GRANT != '0) begin
      chk("grant_onehot", DW'($onehot(bus.READ_GRANT)), 1);
      for (int i = 0; i < W; i++) begin
        if (bus.READ_GRANT[i]) begin
          if (src[i].size() == 0 || !en[i]) begin
            chk("pop_legal", 0, 1);
          end else begin
            pend_w = src[i].pop_front();
            pend   = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(negedge CLK);
    drive();
    #4;
    sample();
  endtask

  // Spec-level model: from the initial queue contents, walk
  // the picks (RR from channel 0 after reset, or lowest
  // index), each taking up to MB words.
  task automatic build_exp();
    int rem[W];
    int tk[W];
    int last;
    int pick;
    int n;
    int c;
    last = W - 1;
    for (int i = 0; i < W; i++) begin
      rem[i] = src[i].size();
      tk[i]  = 0;
    end
    while (1) begin
      pick = -1;
      for (int k = 0; k < W; k++) begin
        c = mode ? k : (last + 1 + k) % W;
        if (pick < 0 && en[c] && rem[c] > 0) pick = c;
      end
      if (pick < 0) break;
      n = rem[pick];
      if (MB != 0 && n > MB) n = MB;
      for (int j = 0; j < n; j++)
        exp_q.push_back(src[pick][tk[pick] + j]);
      tk[pick]  += n;
      rem[pick] -= n;
      last = pick;
    end
  endtask

  task automatic do_reset();
    rst_c = 1'b1;
    hold  = '0;
    en    = '1;
    mode  = 1'b0;
    rmode = 0;
    for (int i = 0; i < W; i++) src[i].delete();
    step();
    step();
    rst_c = 1'b0;
    exp_q.delete();
    acc_cyc.delete();
    pend = 1'b0;
  endtask

  task automatic run_done(input string nm, input int bound);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || bus.WRITE_OUT) &&
           k < bound) begin
      step();
      k++;
    end
    chk({nm, "_complete"}, DW'(exp_q.size() == 0), 1);
    step();
    step();
  endtask

  // Monitor: every accepted word must be the next expected.
  initial begin
    logic          stall;
    logic [DW-1:0] pd;
    stall = 1'b0;
    pd    = '0;
    forever begin
      @(negedge CLK);
      #4;
      mcyc++;
      if (RST) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("stall_valid", DW'(bus.WRITE_OUT), 1);
          chk("stall_data", bus.DATA_OUT, pd);
        end
        if (bus.WRITE_OUT && bus.READY_OUT) begin
          acc_cyc.push_back(mcyc);
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_word: got %0h expected none",
                     bus.DATA_OUT);
          end else begin
            chk("out_order", bus.DATA_OUT, exp_q.pop_front());
          end
        end
        stall = bus.WRITE_OUT && !bus.READY_OUT;
        pd    = bus.DATA_OUT;
      end
    end
  end

  initial begin
    int k;
    bus.WRITE_REQ  = '0;
    bus.HOLD_REQ   = '0;
    bus.DATA_IN    = '0;
    bus.CHANNEL_EN = '0;
    bus.PRIO_MODE  = 1'b0;
    bus.READY_OUT  = 1'b1;

    do_reset();
    chk("reset_write_out", DW'(bus.WRITE_OUT), 0);
    chk("reset_busy", DW'(bus.BUSY), 0);
    chk("reset_cur_ch", DW'(bus.CUR_CH), 0);
    chk("reset_data_out", bus.DATA_OUT, 0);
    chk("reset_grant", DW'(bus.READ_GRANT), 0);

    // Round-robin, two channels of three words.
    do_reset();
    load(1, 3);
    load(3, 3);
    build_exp();
    run_done("rr", 100);
    chk("rr_count", DW'(acc_cyc.size()), 6);
    if (acc_cyc.size() >= 4) begin
      chk("rr_throughput", DW'(acc_cyc[1] - acc_cyc[0]), 1);
      chk("rr_bubble", DW'(acc_cyc[3] - acc_cyc[2] >= 2), 1);
    end

    // Burst limit splits the long channel.
    do_reset();
    load(0, 10);
    load(2, 2);
    rmode = 2;
    build_exp();
    run_done("burst", 200);

    // Hold on empty ch0 blocks ch4.
    do_reset();
    load(0, 1);
    load(4, 3);
    hold = 5'b00001;
    build_exp();
    k = 0;
    while (src[0].size() != 0 && k < 20) begin
      step();
      k++;
    end
    chk("hold_ch0_popped", DW'(src[0].size()), 0);
    repeat (5) begin
      step();
      chk("hold_busy", DW'(bus.BUSY), 1);
      chk("hold_cur_ch", DW'(bus.CUR_CH), 0);
      chk("hold_grant", DW'(bus.READ_GRANT), 0);
    end
    chk("hold_ch4_kept", DW'(src[4].size()), 3);
    hold = '0;
    run_done("hold", 100);

    // Downstream stalls every other cycle.
    do_reset();
    load(2, 6);
    rmode = 1;
    build_exp();
    run_done("stall", 100);
    chk("stall_count", DW'(acc_cyc.size()), 6);

    // Fixed priority, then ch1 masked off.
    do_reset();
    mode = 1'b1;
    load(3, 6);
    load(1, 6);
    build_exp();
    run_done("fixed", 200);
    do_reset();
    mode = 1'b1;
    en   = 5'b11101;
    load(1, 4);
    load(3, 3);
    build_exp();
    run_done("fixed_en", 100);
    chk("en_blocks_ch1", DW'(src[1].size()), 4);

    // Reset in the middle of a ch2 burst.
    do_reset();
    load(2, 8);
    build_exp();
    k = 0;
    while (acc_cyc.size() < 2 && k < 30) begin
      step();
      k++;
    end
    chk("rst_reached", DW'(acc_cyc.size() >= 2), 1);
    rst_c = 1'b1;
    step();
    chk("rst_no_pop", DW'(bus.READ_GRANT), 0);
    rst_c = 1'b0;
    exp_q.delete();
    pend = 1'b0;
    load(0, 2);
    build_exp();
    step();
    chk("rst_write_out", DW'(bus.WRITE_OUT), 0);
    chk("rst_grant", DW'(bus.READ_GRANT), 0);
    chk("rst_busy", DW'(bus.BUSY), 0);
    chk("rst_data_out", bus.DATA_OUT, 0);
    k = 0;
    while (!bus.BUSY && k < 10) begin
      step();
      k++;
    end
    chk("rst_first_pick", DW'(bus.CUR_CH), 0);
    run_done("rst", 100);
    chk("rst_src_drained", DW'(src[2].size()), 0);

    // Randomized contents, masks, modes and backpressure.
    repeat (6) begin
      do_reset();
      mode  = 1'($urandom_range(0, 1));
      en    = 5'($urandom) | 5'b00100;
      rmode = 2;
      for (int c = 0; c < W; c++) load(c, $urandom_range(0, 6));
      build_exp();
      run_done("rand", 600);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
